// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined funnel shifter: mode encodings and the
// funnel-vector builder used by both the datapath and its reference model.
package shifter_pkg;

  localparam logic [1:0] SH_LOGICAL = 2'd0;
  localparam logic [1:0] SH_ARITH   = 2'd1;
  localparam logic [1:0] SH_ROTATE  = 2'd2;

  // Widest datapath the funnel builder supports; callers truncate the result.
  localparam int unsigned FS_MAX_W   = 64;
  localparam int unsigned FS_Z_W     = 2 * FS_MAX_W - 1;
  localparam int unsigned FS_DIDX_W  = $clog2(FS_MAX_W);
  localparam int unsigned FS_ZIDX_W  = $clog2(FS_Z_W);

  // Builds Z (2*width-1 bits, zero-extended) such that result = Z[s +: width],
  // with s = k for right shifts and s = ~k for left shifts.
  function automatic logic [FS_Z_W-1:0] funnel_vec(
    input logic [FS_MAX_W-1:0] data,
    input int unsigned         width,
    input logic                left,
    input logic [1:0]          mode
  );
    logic [FS_Z_W-1:0] z;
    z = '0;
    for (int unsigned b = 0; b < FS_Z_W; b++) begin
      if (b < 2 * width - 1) begin
        if (left) begin
          if (b >= width - 1)
            z[FS_ZIDX_W'(b)] = data[FS_DIDX_W'(b - (width - 1))];
          else if (mode == SH_ROTATE)
            z[FS_ZIDX_W'(b)] = data[FS_DIDX_W'(b + 1)];
        end else begin
          if (b < width)
            z[FS_ZIDX_W'(b)] = data[FS_DIDX_W'(b)];
          else if (mode == SH_ROTATE)
            z[FS_ZIDX_W'(b)] = data[FS_DIDX_W'(b - width)];
          else if (mode == SH_ARITH)
            z[FS_ZIDX_W'(b)] = data[FS_DIDX_W'(width - 1)];
        end
      end
    end
    return z;
  endfunction

endpackage

// File: rtl/funnel_shift_stage.sv
// One registered mux level of the funnel: drops the low STEP bits when the
// current shift bit is set, and forwards the remaining shift bits and tag.
module funnel_shift_stage
  import shifter_pkg::*;
#(
  parameter  int unsigned IN_W  = 15,
  parameter  int unsigned STEP  = 1,
  parameter  int unsigned K_W   = 3,
  parameter  int unsigned TAG_W = 4,
  localparam int unsigned OUT_W = IN_W - STEP,
  localparam int unsigned KO_W  = (K_W > 1) ? K_W - 1 : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_vec,
  input  logic [K_W-1:0]   i_k,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_vec,
  output logic [KO_W-1:0]  o_k,
  output logic [TAG_W-1:0] o_tag
);

  logic             r_valid;
  logic [OUT_W-1:0] r_vec;
  logic [KO_W-1:0]  r_k;
  logic [TAG_W-1:0] r_tag;

  logic [OUT_W-1:0] w_vec;
  logic [KO_W-1:0]  w_k;

  assign w_vec = i_k[0] ? i_vec[IN_W-1:STEP] : i_vec[OUT_W-1:0];
  // The last stage has no remaining shift bits, so its 1-bit k field is always zero.
  assign w_k   = KO_W'(i_k >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_k     <= '0;
      r_tag   <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_vec   <= w_vec;
      r_k     <= w_k;
      r_tag   <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_vec   = r_vec;
  assign o_k     = r_k;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_funnel_shifter.sv
// Pipelined funnel shifter: logical/arithmetic/rotate shifts in both directions,
// one registered stage per shift-amount bit, with a global-stall handshake.
module pipelined_funnel_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned TAG_W   = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_k,
  input  logic               in_left,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned Z_W = 2 * WIDTH - 1;

  logic               w_stall;
  logic               w_accept;
  logic [Z_W-1:0]     w_funnel;
  logic [SHAMT_W-1:0] w_s;
  logic               w_unused_k;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~rst;
  assign w_accept = in_valid & in_ready;

  // Left shifts select from the top of the funnel: s = WIDTH-1-k.
  assign w_funnel = Z_W'(funnel_vec(FS_MAX_W'(in_data), WIDTH, in_left, in_mode));
  assign w_s      = in_left ? ~in_k : in_k;

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    localparam int unsigned STEP = 2 ** gi;
    localparam int unsigned IN_W = 2 * WIDTH - STEP;
    localparam int unsigned K_W  = SHAMT_W - gi;
    localparam int unsigned KO_W = (K_W > 1) ? K_W - 1 : 1;

    logic                 w_in_valid;
    logic [IN_W-1:0]      w_in_vec;
    logic [K_W-1:0]       w_in_k;
    logic [TAG_W-1:0]     w_in_tag;
    logic                 w_valid;
    logic [IN_W-STEP-1:0] w_vec;
    logic [KO_W-1:0]      w_k;
    logic [TAG_W-1:0]     w_tag;

    if (gi == 0) begin : g_head
      assign w_in_valid = w_accept;
      assign w_in_vec   = w_funnel;
      assign w_in_k     = w_s;
      assign w_in_tag   = in_tag;
    end else begin : g_tail
      assign w_in_valid = g_stage[gi-1].w_valid;
      assign w_in_vec   = g_stage[gi-1].w_vec;
      assign w_in_k     = g_stage[gi-1].w_k;
      assign w_in_tag   = g_stage[gi-1].w_tag;
    end

    funnel_shift_stage #(
      .IN_W  (IN_W),
      .STEP  (STEP),
      .K_W   (K_W),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (~w_stall),
      .i_valid (w_in_valid),
      .i_vec   (w_in_vec),
      .i_k     (w_in_k),
      .i_tag   (w_in_tag),
      .o_valid (w_valid),
      .o_vec   (w_vec),
      .o_k     (w_k),
      .o_tag   (w_tag)
    );
  end

  assign out_valid  = g_stage[SHAMT_W-1].w_valid;
  assign out_data   = g_stage[SHAMT_W-1].w_vec;
  assign out_tag    = g_stage[SHAMT_W-1].w_tag;
  assign w_unused_k = g_stage[SHAMT_W-1].w_k[0];

endmodule

// File: tb/tb_pipelined_funnel_shifter.sv
// Scoreboard bench for pipelined_funnel_shifter (WIDTH=8): directed vectors,
// stall/reset scenarios and an exhaustive sweep against an operator-based model.
module tb_pipelined_funnel_shifter;
  import shifter_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [2:0]    in_k = '0;
  logic          in_left = 1'b0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  pipelined_funnel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .in_left   (in_left),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference built from SV shift operators.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [2:0] k,
                                             input logic l, input logic [1:0] m);
    logic [W-1:0] r;
    if (m == SH_ROTATE)
      r = l ? W'((d << k) | (d >> (W - k))) : W'((d >> k) | (d << (W - k)));
    else if (m == SH_ARITH && !l)
      r = W'($signed(d) >>> k);
    else
      r = l ? W'(d << k) : W'(d >> k);
    return r;
  endfunction

  // Monitor: pops and compares on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got data 0x%0h tag %0d, expected no output (cycle %0d)",
                 out_data, out_tag, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic [2:0] k, input logic l,
                      input logic [1:0] m, input logic [TW-1:0] t, input logic [W-1:0] e,
                      input bit lat);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    in_left  = l;
    in_mode  = m;
    in_tag   = t;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back('{e, t, cyc, lat});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL accept_timeout: tag %0d got in_ready=0, expected 1", t);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] seq_a [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [W-1:0] seq_b [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    logic [FS_Z_W-1:0] z;
    logic [2:0]        s;
    logic [W-1:0]      rv;
    logic [W-1:0]      cap_d;
    logic [TW-1:0]     cap_t;
    int                tg;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single operations on 8'hB4, k=3
    send(8'hB4, 3'd3, 1'b0, SH_LOGICAL, 4'd1, 8'h16, 1'b1); drain();
    send(8'hB4, 3'd3, 1'b0, SH_ARITH,   4'd2, 8'hF6, 1'b1); drain();
    send(8'hB4, 3'd3, 1'b1, SH_LOGICAL, 4'd3, 8'hA0, 1'b1); drain();
    send(8'hB4, 3'd3, 1'b0, SH_ROTATE,  4'd4, 8'h96, 1'b1); drain();
    send(8'hB4, 3'd3, 1'b1, SH_ROTATE,  4'd5, 8'hA5, 1'b1); drain();
    send(8'hB4, 3'd3, 1'b1, SH_ARITH,   4'd6, 8'hA0, 1'b1); drain();

    // k = 0 is identity in every mode and direction
    for (int m = 0; m < 3; m++)
      for (int l = 0; l < 2; l++)
        send(8'h5A, 3'd0, 1'(l), 2'(m), 4'(2 * m + l), 8'h5A, 1'b1);
    drain();

    // Reserved mode behaves as logical; arithmetic fills with the sign
    send(8'h80, 3'd7, 1'b0, 2'd3,     4'd7, 8'h01, 1'b1);
    send(8'h80, 3'd7, 1'b0, SH_ARITH, 4'd8, 8'hFF, 1'b1);
    drain();

    // Back-to-back stream, no backpressure
    for (int i = 0; i < 8; i++)
      send(8'h01, 3'(i), 1'b1, SH_ROTATE, 4'(i), seq_a[i], 1'b1);
    drain();

    // Same stream with a 5-cycle stall once the first result appears
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'h80, 3'(i), 1'b0, SH_ROTATE, 4'(i), seq_b[i], 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
        chk("stall_out_valid_rise", 32'(out_valid), 32'd1);
        cap_d = out_data;
        cap_t = out_tag;
        chk("stall_first_tag", 32'(cap_t), 32'd0);
        for (int i = 0; i < 5; i++) begin
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_data_hold", 32'(out_data), 32'(cap_d));
          chk("stall_tag_hold", 32'(out_tag), 32'(cap_t));
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight
    send(8'hFF, 3'd1, 1'b1, SH_LOGICAL, 4'd1, 8'hFE, 1'b1);
    send(8'hFF, 3'd2, 1'b1, SH_LOGICAL, 4'd2, 8'hFC, 1'b1);
    send(8'hFF, 3'd3, 1'b1, SH_LOGICAL, 4'd3, 8'hF8, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'd0);
    chk("flush_out_tag", 32'(out_tag), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;
    send(8'hB4, 3'd3, 1'b0, SH_ARITH, 4'd9, 8'hF6, 1'b1);
    drain();

    // Exhaustive sweep against the operator model; also cross-checks the package funnel
    tg = 0;
    for (int d = 0; d < 256; d++)
      for (int k = 0; k < 8; k++)
        for (int m = 0; m < 4; m++)
          for (int l = 0; l < 2; l++) begin
            rv = ref_shift(8'(d), 3'(k), 1'(l), 2'(m));
            z  = funnel_vec(FS_MAX_W'(d), W, 1'(l), 2'(m));
            s  = (l != 0) ? ~3'(k) : 3'(k);
            chk("pkg_funnel", 32'(z[s +: W]), 32'(rv));
            send(8'(d), 3'(k), 1'(l), 2'(m), 4'(tg), rv, 1'b1);
            tg++;
          end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
